// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and colour codes for the overlay pipeline.
// Overlays and the output stage import the same transparent key from here.
package vga_pkg;

   typedef logic [9:0] coord_t;
   typedef logic [5:0] rgb_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   // RRGGBB
   localparam rgb_t COLOR_TRANSPARENT = 6'b100001;
   localparam rgb_t COLOR_BLACK       = 6'b000000;
   localparam rgb_t COLOR_GOLD        = 6'b111000;
   localparam rgb_t COLOR_RED         = 6'b110000;
   localparam rgb_t COLOR_WHITE       = 6'b111111;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/pixel bundle between the timing source (master) and the overlay side (slave).
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic       pix_en;
   rgb_t       rgb_in;
   rgb_t       bg_rgb;
   coord_t     x;
   coord_t     y;
   logic       active;
   logic       frame_start;
   logic [7:0] frame_count;
   rgb_t       vga_rgb;
   logic       vga_hsync;
   logic       vga_vsync;

   modport master (
      input  pix_en, rgb_in, bg_rgb,
      output x, y, active, frame_start, frame_count, vga_rgb, vga_hsync, vga_vsync
   );

   modport slave (
      output pix_en, rgb_in, bg_rgb,
      input  x, y, active, frame_start, frame_count, vga_rgb, vga_hsync, vga_vsync
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible-area and sync decodes.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   output coord_t count,
   output logic   wrap,
   output logic   visible,
   output logic   sync_n
);

   localparam coord_t LAST       = coord_t'(ACTIVE + FP + SYNC + BP - 1);
   localparam coord_t ACTIVE_END = coord_t'(ACTIVE);
   localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
   localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

   // NOTE: the async reset clears the position the instant rst rises, not at the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
         count <= wrap ? '0 : count + coord_t'(1);
      end
   end

   // wrap is the terminal-count level; the parent qualifies it with its enable.
   assign wrap    = (count == LAST);
   assign visible = (count < ACTIVE_END);
   assign sync_n  = !((count >= SYNC_START) && (count < SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source plus registered pixel/sync pin stage with colour keying.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input logic               clk,
   input logic               rst,
   vga_timing_gen_if.master  bus
);

   coord_t h_count, v_count;
   logic   h_wrap, v_wrap, h_vis, v_vis, h_sync_n, v_sync_n;
   logic   v_en;
   rgb_t   pixel;

   assign v_en = h_wrap & bus.pix_en;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
   ) u_h_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.pix_en),
      .count   (h_count),
      .wrap    (h_wrap),
      .visible (h_vis),
      .sync_n  (h_sync_n)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
   ) u_v_axis (
      .clk     (clk),
      .rst     (rst),
      .en      (v_en),
      .count   (v_count),
      .wrap    (v_wrap),
      .visible (v_vis),
      .sync_n  (v_sync_n)
   );

   assign bus.x           = h_count;
   assign bus.y           = v_count;
   assign bus.active      = h_vis & v_vis;
   assign bus.frame_start = (h_count == '0) && (v_count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.frame_count <= '0;
      end else if (v_en && v_wrap) begin
         bus.frame_count <= bus.frame_count + 8'd1;
      end
   end

   // Blanked pixels are forced black; the overlay's key colour shows the background.
   always_comb begin
      pixel = COLOR_BLACK;
      if (bus.active) begin
         pixel = (bus.rgb_in == COLOR_TRANSPARENT) ? bus.bg_rgb : bus.rgb_in;
      end
   end

   // Colour and both syncs share one register stage so the pins stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.vga_rgb   <= COLOR_BLACK;
         bus.vga_hsync <= 1'b1;
         bus.vga_vsync <= 1'b1;
      end else if (bus.pix_en) begin
         bus.vga_rgb   <= pixel;
         bus.vga_hsync <= h_sync_n;
         bus.vga_vsync <= v_sync_n;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 timing instance for line-level checks, and a
// reduced-geometry instance (16x10 raster) for frame wrap, vsync width and frame_count roll-over.
module tb_vga_timing_gen;

   logic clk;
   logic rst_a, rst_b;
   int   total = 0;
   int   bad   = 0;

   vga_timing_gen_if bus_a ();
   vga_timing_gen_if bus_b ();

   vga_timing_gen dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   // 8+2+3+3 = 16 per line, sync at x 10..12; 6+1+2+1 = 10 lines, vsync at y 7..8
   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.pix_en = 1'b0;  bus_a.rgb_in = '0;  bus_a.bg_rgb = 6'b000011;
      bus_b.pix_en = 1'b0;  bus_b.rgb_in = '0;  bus_b.bg_rgb = 6'b000011;
      adv(2);

      // reset state
      chk("rst_x",      32'(bus_a.x), 0);
      chk("rst_y",      32'(bus_a.y), 0);
      chk("rst_active", 32'(bus_a.active), 1);
      chk("rst_fstart", 32'(bus_a.frame_start), 1);
      chk("rst_rgb",    32'(bus_a.vga_rgb), 0);
      chk("rst_hsync",  32'(bus_a.vga_hsync), 1);
      chk("rst_vsync",  32'(bus_a.vga_vsync), 1);
      chk("rst_fcount", 32'(bus_a.frame_count), 0);

      // ---------------- full-timing instance ----------------
      rst_a = 1'b0;
      bus_a.pix_en = 1'b1;
      adv(1);
      chk("first_x",      32'(bus_a.x), 1);
      chk("first_y",      32'(bus_a.y), 0);
      chk("first_fstart", 32'(bus_a.frame_start), 0);

      adv(638);
      chk("x639",        32'(bus_a.x), 639);
      chk("active_639",  32'(bus_a.active), 1);
      adv(1);
      chk("active_640",  32'(bus_a.active), 0);

      adv(16);
      chk("x656",        32'(bus_a.x), 656);
      chk("hsync_at656", 32'(bus_a.vga_hsync), 1);
      adv(1);
      chk("hsync_fall",  32'(bus_a.vga_hsync), 0);
      n = 0;
      while (bus_a.vga_hsync === 1'b0 && n < 200) begin
         adv(1);
         n++;
      end
      chk("hsync_width", n, 96);
      chk("x_hs_end",    32'(bus_a.x), 753);

      adv(46);
      chk("x799",   32'(bus_a.x), 799);
      chk("y0_end", 32'(bus_a.y), 0);
      adv(1);
      chk("wrap_x", 32'(bus_a.x), 0);
      chk("wrap_y", 32'(bus_a.y), 1);

      // keying at (10,10)
      adv(9 * 800 + 10);
      chk("x10", 32'(bus_a.x), 10);
      chk("y10", 32'(bus_a.y), 10);
      bus_a.rgb_in = 6'b100001;
      adv(1);
      chk("key_bg", 32'(bus_a.vga_rgb), 'b000011);
      bus_a.rgb_in = 6'b110110;
      adv(1);
      chk("key_pass", 32'(bus_a.vga_rgb), 'b110110);

      // horizontal blanking at (700,10)
      adv(688);
      chk("x700", 32'(bus_a.x), 700);
      bus_a.rgb_in = 6'b111111;
      adv(1);
      chk("hblank_rgb", 32'(bus_a.vga_rgb), 0);

      // enable gating, at (20,11)
      adv(119);
      chk("x20", 32'(bus_a.x), 20);
      chk("y11", 32'(bus_a.y), 11);
      chk("rgb_before", 32'(bus_a.vga_rgb), 'b111111);
      bus_a.rgb_in = 6'b010101;
      bus_a.pix_en = 1'b0;
      adv(1);
      chk("hold_x",   32'(bus_a.x), 20);
      chk("hold_rgb", 32'(bus_a.vga_rgb), 'b111111);
      bus_a.pix_en = 1'b1;
      adv(1);
      chk("en_x",   32'(bus_a.x), 21);
      chk("en_rgb", 32'(bus_a.vga_rgb), 'b010101);
      for (int i = 0; i < 1600; i++) begin
         bus_a.pix_en = (i % 2 == 0);
         adv(1);
      end
      chk("toggle_line_x", 32'(bus_a.x), 21);
      chk("toggle_line_y", 32'(bus_a.y), 12);

      // async reset mid-line, checked before any clock edge
      rst_a = 1'b1;
      #1;
      chk("arst_x",      32'(bus_a.x), 0);
      chk("arst_y",      32'(bus_a.y), 0);
      chk("arst_rgb",    32'(bus_a.vga_rgb), 0);
      chk("arst_fstart", 32'(bus_a.frame_start), 1);
      bus_a.pix_en = 1'b0;
      adv(1);

      // ---------------- reduced-geometry instance ----------------
      rst_b = 1'b0;
      bus_b.pix_en = 1'b1;
      adv(159);
      chk("b_last_x",  32'(bus_b.x), 15);
      chk("b_last_y",  32'(bus_b.y), 9);
      chk("b_fc0",     32'(bus_b.frame_count), 0);
      adv(1);
      chk("b_wrap_x",  32'(bus_b.x), 0);
      chk("b_wrap_y",  32'(bus_b.y), 0);
      chk("b_fstart",  32'(bus_b.frame_start), 1);
      chk("b_fc1",     32'(bus_b.frame_count), 1);

      n = 0;
      for (int i = 0; i < 160; i++) begin
         adv(1);
         if (bus_b.vga_vsync === 1'b0) n++;
      end
      chk("b_vsync_width", n, 32);
      chk("b_fc2",         32'(bus_b.frame_count), 2);

      // vertical blanking at (2,6)
      adv(98);
      chk("b_y6",     32'(bus_b.y), 6);
      chk("b_active", 32'(bus_b.active), 0);
      bus_b.rgb_in = 6'b111111;
      adv(1);
      chk("vblank_rgb", 32'(bus_b.vga_rgb), 0);
      adv(61);
      chk("b_fc3", 32'(bus_b.frame_count), 3);

      adv(252 * 160 + 159);
      chk("b_fc255", 32'(bus_b.frame_count), 255);
      adv(1);
      chk("b_fc_roll", 32'(bus_b.frame_count), 0);
      chk("b_roll_fs", 32'(bus_b.frame_start), 1);

      // async reset mid-frame at (3,5) with frame_count=1
      adv(160 + 83);
      chk("b_x3",  32'(bus_b.x), 3);
      chk("b_y5",  32'(bus_b.y), 5);
      chk("b_fc1b", 32'(bus_b.frame_count), 1);
      rst_b = 1'b1;
      #1;
      chk("b_arst_x",  32'(bus_b.x), 0);
      chk("b_arst_y",  32'(bus_b.y), 0);
      chk("b_arst_fc", 32'(bus_b.frame_count), 0);
      chk("b_arst_hs", 32'(bus_b.vga_hsync), 1);
      chk("b_arst_vs", 32'(bus_b.vga_vsync), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
